// File: rtl/flag_unit.sv
// Condition-flag generator and holder. It captures an ALU result, commits the
// masked flags one cycle later, and keeps a small LIFO that saves and restores flags.
module flag_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_valid,
    input  logic [5:0]       upd_mask,
    input  logic             upd_sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] result,
    input  logic             carry,
    input  logic             save,
    input  logic             restore,
    input  logic             clear_err,
    output logic [5:0]       flags,
    output logic             pending,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Stage-1 capture registers
    logic             s1_valid_q, s1_valid_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [5:0]       mask_q, mask_d;

    logic [5:0]       flags_q, flags_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [5:0]       stack_mem [DEPTH];

    logic [5:0]       new_flags;
    logic [5:0]       commit_flags;
    logic             is_full, is_empty;
    logic             do_push, do_pop, err_event;
    logic [CW-1:0]    cnt_m1;
    logic [AW-1:0]    top_idx, push_idx;
    logic             z_f, n_f, v_f;

    // Only the operand sign bits matter for overflow detection.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{op_a[WIDTH-2:0], op_b[WIDTH-2:0]};

    always_comb begin
        s1_valid_d = upd_valid;
        a_msb_d    = upd_valid ? op_a[WIDTH-1] : a_msb_q;
        b_msb_d    = upd_valid ? op_b[WIDTH-1] : b_msb_q;
        res_d      = upd_valid ? result        : res_q;
        carry_d    = upd_valid ? carry         : carry_q;
        sub_d      = upd_valid ? upd_sub       : sub_q;
        mask_d     = upd_valid ? upd_mask      : mask_q;
    end

    always_comb begin
        z_f = (res_q == '0);
        n_f = res_q[WIDTH-1];
        if (sub_q) begin
            v_f = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
        end else begin
            v_f = (a_msb_q == b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
        end
        new_flags = {~^res_q, n_f ^ v_f, v_f, carry_q, n_f, z_f};
        commit_flags = s1_valid_q ? ((flags_q & ~mask_q) | (new_flags & mask_q)) : flags_q;
    end

    always_comb begin
        is_full   = (cnt_q == CW'(DEPTH));
        is_empty  = (cnt_q == '0);
        do_push   = save & ~restore & ~is_full;
        do_pop    = restore & ~save & ~is_empty;
        err_event = (save & restore) | (save & ~restore & is_full) | (restore & ~save & is_empty);
        cnt_m1    = cnt_q - CW'(1);
        top_idx   = cnt_m1[AW-1:0];
        push_idx  = cnt_q[AW-1:0];

        // A pop overrides any commit landing in the same cycle.
        flags_d = do_pop ? stack_mem[top_idx] : commit_flags;

        cnt_d = cnt_q;
        if (do_push) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop) begin
            cnt_d = cnt_m1;
        end

        err_d = err_q;
        if (err_event) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            sub_q      <= 1'b0;
            mask_q     <= '0;
            flags_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            sub_q      <= sub_d;
            mask_q     <= mask_d;
            flags_q    <= flags_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // The stack contents are not reset; the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[push_idx] <= commit_flags;
        end
    end

    assign flags       = flags_q;
    assign pending     = s1_valid_q;
    assign stack_full  = is_full;
    assign stack_empty = is_empty;
    assign stack_err   = err_q;
endmodule

// File: doc/flag_unit.md
# flag_unit

Status-flag generator and holder for the datapath. Captures each ALU result with its operands, computes the six condition flags one cycle later, and commits them (bitwise masked) to the `flags` register read by branch-condition evaluation. Includes a small save/restore stack so interrupt entry and exit preserve the flags.

## Interface
- `WIDTH`, 32: ALU operand and result width.
- `DEPTH`, 4: save-stack entries; must be a power of two, ≥ 2.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `upd_valid` in 1: ALU result present this cycle; capture it.
- `upd_mask` in 6: per-flag write enable, applied at commit.
- `upd_sub` in 1: operation was a subtraction (`a - b`); selects the overflow rule.
- `op_a` in WIDTH: ALU operand A.
- `op_b` in WIDTH: ALU operand B.
- `result` in WIDTH: ALU result.
- `carry` in 1: ALU carry/borrow out.
- `save` in 1: push the flags onto the stack.
- `restore` in 1: pop the top of the stack into `flags`.
- `clear_err` in 1: clear `stack_err`.
- `flags` out 6: committed flags.
- `pending` out 1: an update is captured but not yet committed.
- `stack_full` out 1: the stack holds DEPTH entries.
- `stack_empty` out 1: the stack holds 0 entries.
- `stack_err` out 1: sticky error, set by overflow, underflow, or a save/restore conflict.

## Operation
- **Flag encoding.**
  - `[0]` Z: `result == 0`.
  - `[1]` N: `result[WIDTH-1]`.
  - `[2]` C: `carry`.
  - `[3]` V, add: `a_msb == b_msb && r_msb != a_msb`.
  - `[3]` V, sub: `a_msb != b_msb && r_msb != a_msb`.
  - `[4]` LT: `N ^ V`.
  - `[5]` P: 1 when `result` has an even number of ones.
- **Stage 1 (capture).** On `upd_valid`, register `op_a` MSB, `op_b` MSB, `result`, `carry`, `upd_sub` and `upd_mask`, and set `s1_valid`. The stage reloads every cycle `upd_valid` is high; back-to-back updates are fully pipelined.
- **Stage 2 (commit).** When `s1_valid` is set, compute the flags from the stage-1 registers. Write only the bits set in the captured mask; other bits hold. Clear `s1_valid` unless a new capture occurs in the same cycle.
- **`pending`.** Equals `s1_valid`.
- **Save.** Push the post-commit flag value, i.e. including any commit in the same cycle, so an in-flight update is never lost.
- **Restore.**
  - Load `flags` from the top entry and pop it.
  - If a commit falls in the same cycle, restore wins and that commit is discarded.
  - A capture in the same cycle still proceeds and commits next cycle over the restored value.
- **Boundary conditions.**
  - Save when full: stack unchanged, `stack_err` set.
  - Restore when empty: `flags` unchanged (a same-cycle commit proceeds normally), `stack_err` set.
  - Save and restore in the same cycle: both ignored, `stack_err` set, commit proceeds normally.
  - `clear_err` with a same-cycle error event: `stack_err` stays 1.
- **Stack.** LIFO with a pointer/count of width `clog2(DEPTH)+1`. `stack_full` and `stack_empty` are decoded from the count, registered-state only.

## Timing
- **Reset (async, while `rst_n` = 0):**
  - `flags` = 6'b000000
  - `pending` = 0
  - count = 0
  - `stack_empty` = 1
  - `stack_full` = 0
  - `stack_err` = 0
  - Stack contents are don't-care.
- **Reset mid-operation.** Any captured update is discarded. No commit occurs after `rst_n` rises until a new `upd_valid`.
- **Update latency.** `upd_valid` sampled at edge N → `pending` high for the cycle after edge N → new `flags` visible after edge N+1. Consumers must not evaluate branches while `pending` = 1.
- **Save/restore.** Take effect at the sampling edge. Stack status outputs update at the same edge.
- **Outputs.** All outputs are registered; none depend combinationally on inputs.

## Test plan
- **Reset.** Reset, then one idle cycle → `flags`=000000, `pending`=0, `stack_empty`=1, `stack_err`=0.
- **Add overflow (WIDTH=32).** Add `0x7FFFFFFF + 1`, `result=0x80000000`, `carry=0`, mask `111111`.
  - Expect `pending`=1 for one cycle.
  - Then flags Z0 N1 C0 V1 LT0 P0 → `flags`=6'b001010.
- **Sub equal with partial mask.** Sub `5 - 5`, `result=0`, `carry=1`, mask `000001`, following the previous case → `flags`=6'b001011 (only Z changes).
- **Back-to-back updates.** Two updates on consecutive cycles (`result=0`, then `result=3`, full mask) → `flags` shows Z=1 for exactly one cycle, then Z=0, P=1; `pending` stays high across both.
- **Stack with DEPTH=4.**
  - 4 saves → `stack_full`=1.
  - 5th save → `stack_err`=1, count stays 4.
  - 4 restores return the saved values in reverse order.
  - A 5th restore keeps `flags` unchanged.
  - `clear_err` → `stack_err`=0.
- **Conflicts.**
  - `save` and `restore` in the same cycle → `stack_err`=1, count unchanged.
  - `restore` in the same cycle as a pending commit → restored value wins; the commit is lost.
